lsu_mem_ctrl: RTL and testbench

- MEM-stage load/store controller sitting directly upstream of the load-data aligner.
- Accepts one load/store per transaction from the EX/MEM register and checks alignment.
- Generates word-aligned address, byte enables and lane-replicated store data for the data-memory port, then runs a req/ack handshake with a timeout.
- Returns the raw 32-bit read word plus the original byte address and mem_op, unmodified, so the aligner can extract and extend the data.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_mem_ctrl_store_lane_gen.sv | 36 +++
 rtl/lsu_mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Encodings shared by the MEM-stage load/store controller and its lane generator.
package lsu_pkg;

  localparam logic [1:0] MEM_BYTE   = 2'b00;
  localparam logic [1:0] MEM_HALF   = 2'b01;
  localparam logic [1:0] MEM_WORD   = 2'b10;
  localparam logic       MEM_SIGNED = 1'b0;

  localparam int MEM_LOAD_BIT  = 3;
  localparam int MEM_STORE_BIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  // Both direction bits set, or the reserved size code.
  function automatic logic op_illegal(input logic [4:0] op);
    return (op[MEM_LOAD_BIT] & op[MEM_STORE_BIT]) | (op[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side request/response and data-memory port of the load/store controller.
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        resp_valid;
  logic [31:0] resp_dataout;
  logic [31:0] resp_addr;
  logic [4:0]  resp_mem_op;
  logic        resp_misalign;
  logic        resp_err;
  logic        stall;

  modport slave (
    input  req_valid, mem_op, addr, wdata, dm_ack, dm_rdata,
    output req_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           resp_valid, resp_dataout, resp_addr, resp_mem_op,
           resp_misalign, resp_err, stall
  );

  modport master (
    output req_valid, mem_op, addr, wdata, dm_ack, dm_rdata,
    input  req_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           resp_valid, resp_dataout, resp_addr, resp_mem_op,
           resp_misalign, resp_err, stall
  );

endinterface

// File: rtl/lsu_mem_ctrl_store_lane_gen.sv
// Combinational map of access size and byte offset to byte enables,
// lane-replicated store data and an alignment fault flag.
module store_lane_gen
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane_dat,
  output logic        o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_lane_dat = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      MEM_BYTE: begin
        o_be       = 4'b0001 << i_off;
        o_lane_dat = {4{i_wdata[7:0]}};
      end
      MEM_HALF: begin
        o_be       = 4'b0011 << i_off;
        o_lane_dat = {2{i_wdata[15:0]}} << {i_off[0], 3'b000};
        o_misalign = (i_off == 2'b11);
      end
      MEM_WORD: begin
        o_be       = 4'b1111;
        o_misalign = (i_off != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: alignment check, data-memory req/ack with timeout,
// and a one-cycle raw response for the downstream load aligner.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave lsu
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_noop;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_ack;
  logic        w_timeout;
  logic        w_go_bus;
  logic        w_resp_ld;
  logic        w_resp_err;
  logic        w_resp_mis;
  logic [31:0] w_resp_dat;
  logic [31:0] w_resp_addr;
  logic [4:0]  w_resp_op;
  logic [3:0]  w_be;
  logic [31:0] w_lane_dat;

  logic        r_dm_req;
  logic        r_dm_we;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [31:0] r_addr;
  logic [4:0]  r_op;

  logic        r_resp_valid;
  logic        r_resp_mis;
  logic        r_resp_err;
  logic [31:0] r_resp_dat;
  logic [31:0] r_resp_addr;
  logic [4:0]  r_resp_op;

  store_lane_gen u_lane (
    .i_size     (lsu.mem_op[1:0]),
    .i_off      (lsu.addr[1:0]),
    .i_wdata    (lsu.wdata),
    .o_be       (w_be),
    .o_lane_dat (w_lane_dat),
    .o_misalign (w_misalign)
  );

  assign w_req_ready = (r_state != BUS);
  assign w_accept    = lsu.req_valid & w_req_ready;
  assign w_noop      = ~lsu.mem_op[MEM_LOAD_BIT] & ~lsu.mem_op[MEM_STORE_BIT];
  assign w_illegal   = op_illegal(lsu.mem_op);
  assign w_ack       = (r_state == BUS) & lsu.dm_ack;
  // An ack arriving in the last allowed cycle takes priority over the timeout.
  assign w_timeout   = (TIMEOUT != 0) && (r_state == BUS) && !lsu.dm_ack && (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_bus    = 1'b0;
    w_resp_err  = 1'b0;
    w_resp_mis  = 1'b0;
    w_resp_dat  = '0;
    w_resp_addr = r_addr;
    w_resp_op   = r_op;
    case (r_state)
      IDLE, RESP: begin
        w_state_nxt = IDLE;
        w_resp_addr = lsu.addr;
        w_resp_op   = lsu.mem_op;
        if (w_accept && !w_noop) begin
          if (w_illegal) begin
            w_state_nxt = RESP;
            w_resp_err  = 1'b1;
          end else if (w_misalign) begin
            w_state_nxt = RESP;
            w_resp_mis  = 1'b1;
          end else begin
            w_state_nxt = BUS;
            w_go_bus    = 1'b1;
          end
        end
      end
      BUS: begin
        if (w_ack) begin
          w_state_nxt = RESP;
          if (r_op[MEM_LOAD_BIT]) begin
            w_resp_dat = lsu.dm_rdata;
          end
        end else if (w_timeout) begin
          w_state_nxt = RESP;
          w_resp_err  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_resp_ld = (w_state_nxt == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_go_bus) begin
      r_cnt <= '0;
    end else if ((r_state == BUS) && !lsu.dm_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Memory-port fields are frozen from accept until the request retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_be    <= '0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
    end else if (w_go_bus) begin
      r_dm_req   <= 1'b1;
      r_dm_we    <= lsu.mem_op[MEM_STORE_BIT];
      r_dm_be    <= w_be;
      r_dm_addr  <= {lsu.addr[31:2], 2'b00};
      r_dm_wdata <= w_lane_dat;
    end else if (w_ack || w_timeout) begin
      r_dm_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_op   <= '0;
    end else if (w_accept) begin
      r_addr <= lsu.addr;
      r_op   <= lsu.mem_op;
    end
  end

  // Response fields only change when a new response is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_mis   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_dat   <= '0;
      r_resp_addr  <= '0;
      r_resp_op    <= '0;
    end else begin
      r_resp_valid <= w_resp_ld;
      if (w_resp_ld) begin
        r_resp_mis  <= w_resp_mis;
        r_resp_err  <= w_resp_err;
        r_resp_dat  <= w_resp_dat;
        r_resp_addr <= w_resp_addr;
        r_resp_op   <= w_resp_op;
      end
    end
  end

  assign lsu.req_ready     = w_req_ready;
  assign lsu.stall         = (lsu.req_valid & ~w_req_ready) | (r_state == BUS);
  assign lsu.dm_req        = r_dm_req;
  assign lsu.dm_we         = r_dm_we;
  assign lsu.dm_be         = r_dm_be;
  assign lsu.dm_addr       = r_dm_addr;
  assign lsu.dm_wdata      = r_dm_wdata;
  assign lsu.resp_valid    = r_resp_valid;
  assign lsu.resp_dataout  = r_resp_dat;
  assign lsu.resp_addr     = r_resp_addr;
  assign lsu.resp_mem_op   = r_resp_op;
  assign lsu.resp_misalign = r_resp_mis;
  assign lsu.resp_err      = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand-written corner sequences,
// and random transactions checked against a behavioural model.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  lsu_mem_ctrl_if bus_if ();

  lsu_mem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
  } stim_t;

  typedef struct packed {
    bit          got_resp;
    int          lat;
    int          req_cycles;
    logic [3:0]  be;
    logic        we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dataout;
    logic [31:0] resp_addr;
    logic [4:0]  resp_op;
    logic        mis;
    logic        err;
    bit          rdy_bad;
    bit          pulse_bad;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                               input int dly, input logic [31:0] rd, input bit got, input int lat,
                               input int reqc, input logic [3:0] be, input logic we,
                               input logic [31:0] dma, input logic [31:0] dmw,
                               input logic [31:0] dout, input logic mis, input logic err);
    vec_t v;
    v = '0;
    v.s.op = op; v.s.addr = a; v.s.wdata = wd; v.s.dly = dly; v.s.rdata = rd;
    v.e.got_resp = got; v.e.lat = lat; v.e.req_cycles = reqc; v.e.be = be; v.e.we = we;
    v.e.dm_addr = dma; v.e.dm_wdata = dmw; v.e.dataout = dout; v.e.mis = mis; v.e.err = err;
    v.e.resp_addr = a; v.e.resp_op = op;
    return v;
  endfunction

  // Behavioural reference: outcome of one transaction from the op, address and ack delay.
  function automatic obs_t model(input stim_t s);
    obs_t e;
    int   off;
    int   nb;
    logic ld;
    logic st;
    logic [1:0] sz;
    e = '0;
    sz = s.op[1:0]; ld = s.op[3]; st = s.op[4]; off = int'(s.addr[1:0]);
    e.resp_addr = s.addr;
    e.resp_op   = s.op;
    if (!ld && !st) return e;
    e.got_resp = 1;
    if ((ld && st) || sz == 2'b11) begin
      e.err = 1; e.lat = 1; return e;
    end
    if ((sz == 2'b01 && off == 3) || (sz == 2'b10 && off != 0)) begin
      e.mis = 1; e.lat = 1; return e;
    end
    nb = 1 << sz;
    e.be = 4'(((1 << nb) - 1) << off);
    e.we = st;
    e.dm_addr = s.addr & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'b00) e.dm_wdata[8*i +: 8] = s.wdata[7:0];
      else if (sz == 2'b10) e.dm_wdata[8*i +: 8] = s.wdata[8*i +: 8];
      else if (i < off % 2) e.dm_wdata[8*i +: 8] = 8'h00;
      else e.dm_wdata[8*i +: 8] = s.wdata[8*((i - off % 2) % 2) +: 8];
    end
    if (s.dly < 0 || s.dly >= 16) begin
      e.req_cycles = 16; e.lat = 17; e.err = 1;
    end else begin
      e.req_cycles = s.dly + 1; e.lat = s.dly + 2;
      e.dataout = ld ? s.rdata : 32'h0;
    end
    return e;
  endfunction

  // Presents one op, plays the memory (ack after dly+1 request cycles, never if dly<0)
  // and records what the DUT did. Starts and ends with the DUT idle, just after a clock edge.
  task automatic do_txn(input stim_t s, output obs_t o);
    bit first;
    o = '0;
    first = 1;
    bus_if.req_valid = 1'b1;
    bus_if.mem_op    = s.op;
    bus_if.addr      = s.addr;
    bus_if.wdata     = s.wdata;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.mem_op    = 5'h0;
    for (int c = 1; c <= 24; c++) begin
      if ((bus_if.req_ready !== !bus_if.dm_req) || (bus_if.stall !== bus_if.dm_req)) o.rdy_bad = 1;
      if (bus_if.resp_valid === 1'b1) begin
        o.got_resp  = 1;
        o.lat       = c;
        o.dataout   = bus_if.resp_dataout;
        o.resp_addr = bus_if.resp_addr;
        o.resp_op   = bus_if.resp_mem_op;
        o.mis       = bus_if.resp_misalign;
        o.err       = bus_if.resp_err;
        break;
      end
      if (bus_if.dm_req === 1'b1) begin
        o.req_cycles++;
        if (first) begin
          o.be = bus_if.dm_be; o.we = bus_if.dm_we;
          o.dm_addr = bus_if.dm_addr; o.dm_wdata = bus_if.dm_wdata;
          first = 0;
        end else if (bus_if.dm_addr !== o.dm_addr || bus_if.dm_be !== o.be ||
                     bus_if.dm_wdata !== o.dm_wdata || bus_if.dm_we !== o.we) begin
          o.rdy_bad = 1;
        end
        bus_if.dm_ack   = (s.dly >= 0) && (o.req_cycles == s.dly + 1);
        bus_if.dm_rdata = bus_if.dm_ack ? s.rdata : $urandom;
      end else begin
        bus_if.dm_ack = 1'b0;
      end
      tick();
    end
    bus_if.dm_ack = 1'b0;
    if (o.got_resp) begin
      tick();
      o.pulse_bad = (bus_if.resp_valid !== 1'b0);
    end
  endtask

  task automatic cmp(input string t, input obs_t a, input obs_t e);
    chk({t, ".resp"}, 32'(a.got_resp), 32'(e.got_resp));
    chk({t, ".reqcyc"}, a.req_cycles, e.req_cycles);
    chk({t, ".handshake"}, {30'h0, a.rdy_bad, a.pulse_bad}, 32'h0);
    if (e.req_cycles > 0) begin
      chk({t, ".be"}, 32'(a.be), 32'(e.be));
      chk({t, ".we"}, 32'(a.we), 32'(e.we));
      chk({t, ".dm_addr"}, a.dm_addr, e.dm_addr);
      chk({t, ".dm_wdata"}, a.dm_wdata, e.dm_wdata);
    end
    if (e.got_resp) begin
      chk({t, ".lat"}, a.lat, e.lat);
      chk({t, ".dataout"}, a.dataout, e.dataout);
      chk({t, ".misalign"}, 32'(a.mis), 32'(e.mis));
      chk({t, ".err"}, 32'(a.err), 32'(e.err));
      chk({t, ".resp_addr"}, a.resp_addr, e.resp_addr);
      chk({t, ".resp_op"}, 32'(a.resp_op), 32'(e.resp_op));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    obs_t       o;
    stim_t      s;
    logic [4:0] legal[8];

    rst = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.mem_op = '0; bus_if.addr = '0; bus_if.wdata = '0;
    bus_if.dm_ack = 1'b0; bus_if.dm_rdata = '0;

    //        op     addr        wdata        dly rdata        got lat req be    we dm_addr      dm_wdata     dataout      mis err
    tbl.push_back(mkv(5'h0A, 32'h104, 32'h0,        3,  32'hDEADBEEF, 1, 5,  4,  4'hF, 0, 32'h104, 32'h0,        32'hDEADBEEF, 0, 0));
    tbl.push_back(mkv(5'h10, 32'h203, 32'hA5,       1,  32'hFFFFFFFF, 1, 3,  2,  4'h8, 1, 32'h200, 32'hA5A5A5A5, 32'h0,        0, 0));
    tbl.push_back(mkv(5'h11, 32'h101, 32'h1234,     0,  32'h77777777, 1, 2,  1,  4'h6, 1, 32'h100, 32'h34123400, 32'h0,        0, 0));
    tbl.push_back(mkv(5'h11, 32'h102, 32'hABCD,     1,  32'h0,        1, 3,  2,  4'hC, 1, 32'h100, 32'hABCDABCD, 32'h0,        0, 0));
    tbl.push_back(mkv(5'h09, 32'h103, 32'h0,        0,  32'h0,        1, 1,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        1, 0));
    tbl.push_back(mkv(5'h0A, 32'h102, 32'h0,        0,  32'h0,        1, 1,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        1, 0));
    tbl.push_back(mkv(5'h11, 32'h103, 32'h5555,     0,  32'h0,        1, 1,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        1, 0));
    tbl.push_back(mkv(5'h0A, 32'h300, 32'h0,        -1, 32'h0,        1, 17, 16, 4'hF, 0, 32'h300, 32'h0,        32'h0,        0, 1));
    tbl.push_back(mkv(5'h0A, 32'h300, 32'h0,        15, 32'h55AA,     1, 17, 16, 4'hF, 0, 32'h300, 32'h0,        32'h55AA,     0, 0));
    tbl.push_back(mkv(5'h1A, 32'h100, 32'h0,        0,  32'h0,        1, 1,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        0, 1));
    tbl.push_back(mkv(5'h0B, 32'h100, 32'h0,        0,  32'h0,        1, 1,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        0, 1));
    tbl.push_back(mkv(5'h0C, 32'h002, 32'hFF,       2,  32'h11223344, 1, 4,  3,  4'h4, 0, 32'h0,   32'hFFFFFFFF, 32'h11223344, 0, 0));
    tbl.push_back(mkv(5'h12, 32'h010, 32'hCAFEF00D, 0,  32'h0,        1, 2,  1,  4'hF, 1, 32'h010, 32'hCAFEF00D, 32'h0,        0, 0));
    tbl.push_back(mkv(5'h00, 32'h055, 32'h0,        0,  32'h0,        0, 0,  0,  4'h0, 0, 32'h0,   32'h0,        32'h0,        0, 0));

    #1;
    chk("reset.req_ready", 32'(bus_if.req_ready), 32'h1);
    chk("reset.dm_req", 32'(bus_if.dm_req), 32'h0);
    chk("reset.resp_valid", 32'(bus_if.resp_valid), 32'h0);
    chk("reset.stall", 32'(bus_if.stall), 32'h0);
    chk("reset.dataout", bus_if.resp_dataout, 32'h0);
    chk("reset.flags", {29'h0, bus_if.resp_err, bus_if.resp_misalign, bus_if.dm_we}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      do_txn(tbl[i].s, o);
      cmp($sformatf("vec%0d", i), o, tbl[i].e);
    end
    chk("hold.resp_addr", bus_if.resp_addr, 32'h055 & 32'h0 | 32'h010);
    chk("hold.resp_valid", 32'(bus_if.resp_valid), 32'h0);

    // Back-to-back: second load presented in the RESP cycle of the first.
    bus_if.req_valid = 1'b1; bus_if.mem_op = 5'h0A; bus_if.addr = 32'h40;
    tick();
    bus_if.req_valid = 1'b0;
    chk("b2b.req1", 32'(bus_if.dm_req), 32'h1);
    bus_if.dm_ack = 1'b1; bus_if.dm_rdata = 32'h1111;
    tick();
    bus_if.dm_ack = 1'b0;
    chk("b2b.resp1", 32'(bus_if.resp_valid), 32'h1);
    chk("b2b.dat1", bus_if.resp_dataout, 32'h1111);
    chk("b2b.ready_in_resp", 32'(bus_if.req_ready), 32'h1);
    bus_if.req_valid = 1'b1; bus_if.addr = 32'h80;
    tick();
    bus_if.req_valid = 1'b0;
    chk("b2b.req2", 32'(bus_if.dm_req), 32'h1);
    chk("b2b.addr2", bus_if.dm_addr, 32'h80);
    chk("b2b.no_resp", 32'(bus_if.resp_valid), 32'h0);
    chk("b2b.hold_dat", bus_if.resp_dataout, 32'h1111);
    bus_if.dm_ack = 1'b1; bus_if.dm_rdata = 32'h2222;
    tick();
    bus_if.dm_ack = 1'b0;
    chk("b2b.resp2", 32'(bus_if.resp_valid), 32'h1);
    chk("b2b.dat2", bus_if.resp_dataout, 32'h2222);
    chk("b2b.raddr2", bus_if.resp_addr, 32'h80);
    tick();
    chk("b2b.pulse", 32'(bus_if.resp_valid), 32'h0);
    chk("b2b.hold_addr", bus_if.resp_addr, 32'h80);

    // Reset while the request is outstanding; later acks must be ignored.
    bus_if.req_valid = 1'b1; bus_if.mem_op = 5'h0A; bus_if.addr = 32'h500;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    chk("rst.in_bus", 32'(bus_if.dm_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst.dm_req", 32'(bus_if.dm_req), 32'h0);
    chk("rst.req_ready", 32'(bus_if.req_ready), 32'h1);
    chk("rst.resp_valid", 32'(bus_if.resp_valid), 32'h0);
    #2;
    rst = 1'b0;
    bus_if.dm_ack = 1'b1; bus_if.dm_rdata = 32'h9999;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst.idle%0d", k), {30'h0, bus_if.resp_valid, bus_if.dm_req}, 32'h0);
    end
    bus_if.dm_ack = 1'b0;
    tick();

    legal[0] = 5'h08; legal[1] = 5'h09; legal[2] = 5'h0A; legal[3] = 5'h0C;
    legal[4] = 5'h0D; legal[5] = 5'h10; legal[6] = 5'h11; legal[7] = 5'h12;
    for (int n = 0; n < 120; n++) begin
      int r;
      s.op    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal[$urandom_range(0, 7)];
      s.addr  = $urandom;
      s.wdata = $urandom;
      s.rdata = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) s.dly = -1;
      else if (r == 1) s.dly = 15;
      else if (r == 2) s.dly = 16;
      else s.dly = $urandom_range(0, 5);
      do_txn(s, o);
      cmp($sformatf("rnd%0d", n), o, model(s));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
